// File: rtl/spine_egress_arbiter.sv
// Round-robin arbiter sharing the single GPU-side egress path among four spine
// inputs, with credit-based flow control toward the NI and sticky error status.
module spine_egress_arbiter #(
  parameter int          DWIDTH     = 16,
  parameter int          CREDITS    = 4,
  parameter logic [5:0]  LOCAL_ADDR = 6'd23
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arb_enable,
  input  logic [4*DWIDTH-1:0] req_data,
  input  logic [3:0]          req_valid,
  output logic [3:0]          req_ready,
  output logic [DWIDTH-1:0]   out_data,
  output logic                out_valid,
  input  logic                credit_in,
  output logic [1:0]          current_grant,
  output logic [3:0]          credit_count,
  output logic                busy,
  output logic                misroute_err,
  output logic                credit_ovf_err
);

  localparam logic [3:0] CRED_MAX = 4'(CREDITS);

  logic [1:0]        last;
  logic [1:0]        winner;
  logic [1:0]        cand;
  logic              found;
  logic              grant;
  logic [DWIDTH-1:0] win_flit;

  // Search order starts one past the last winner, so a lone requester equal
  // to last is reached on the fourth step and re-granted.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    winner = last;
    found  = 1'b0;
    cand   = last;
    for (int k = 1; k <= 4; k++) begin
      cand = last + 2'(k);
      if (!found && req_valid[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // Reset forces the accept low so no upstream flit is consumed during reset.
  assign grant     = !reset && arb_enable && (credit_count != 4'd0) && (|req_valid);
  assign req_ready = grant ? (4'b0001 << winner) : 4'b0000;
  assign win_flit  = req_data[winner*DWIDTH +: DWIDTH];

  assign current_grant = last;
  assign busy          = (credit_count < CRED_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      credit_count   <= CRED_MAX;
      last           <= 2'd3;
      misroute_err   <= 1'b0;
      credit_ovf_err <= 1'b0;
    end else begin
      out_valid <= grant;
      if (grant) begin
        out_data <= win_flit;
        last     <= winner;
        if (win_flit[DWIDTH-1 -: 6] != LOCAL_ADDR)
          misroute_err <= 1'b1;
      end

      // A grant and a returned credit in the same cycle cancel out.
      if (grant && !credit_in) begin
        credit_count <= credit_count - 4'd1;
      end else if (credit_in && !grant) begin
        if (credit_count == CRED_MAX)
          credit_ovf_err <= 1'b1;
        else
          credit_count <= credit_count + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_spine_egress_arbiter.sv
// Scoreboard bench for spine_egress_arbiter: directed scenarios followed by
// randomized traffic, checked against a behavioural model of the arbiter rules.
module tb_spine_egress_arbiter;

  localparam int DW = 16;
  localparam int NCRED = 4;
  localparam logic [5:0] LADDR = 6'd23;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          arb_enable = 1'b0;
  logic [4*DW-1:0] req_data = '0;
  logic [3:0]    req_valid = '0;
  logic [3:0]    req_ready;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          credit_in = 1'b0;
  logic [1:0]    current_grant;
  logic [3:0]    credit_count;
  logic          busy;
  logic          misroute_err;
  logic          credit_ovf_err;

  spine_egress_arbiter #(.DWIDTH(DW), .CREDITS(NCRED), .LOCAL_ADDR(LADDR)) dut (
    .clk(clk), .reset(reset), .arb_enable(arb_enable),
    .req_data(req_data), .req_valid(req_valid), .req_ready(req_ready),
    .out_data(out_data), .out_valid(out_valid), .credit_in(credit_in),
    .current_grant(current_grant), .credit_count(credit_count), .busy(busy),
    .misroute_err(misroute_err), .credit_ovf_err(credit_ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  // Reference state: plain integers following the arbitration rules.
  int m_credits = NCRED;
  int m_last = 3;
  bit m_mis = 0;
  bit m_ovf = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++)
      if (v[(last + k) % 4]) return (last + k) % 4;
    return -1;
  endfunction

  function automatic logic [DW-1:0] flit(input int dest, input int tag);
    logic [5:0] d;
    d = 6'(dest);
    return {d, 10'(tag)};
  endfunction

  // One clock cycle: drive at negedge, check accept, update model at posedge.
  task automatic cycle(input logic r, input logic en, input logic [3:0] v,
                       input logic [4*DW-1:0] d, input logic ci);
    bit g;
    int w;
    logic [DW-1:0] f;
    @(negedge clk);
    reset = r; arb_enable = en; req_valid = v; req_data = d; credit_in = ci;
    #1;
    g = !r && en && (m_credits != 0) && (v != 4'b0);
    w = g ? pick(v, m_last) : -1;
    check("req_ready", {28'b0, req_ready}, g ? (32'd1 << w) : 32'd0);
    f = g ? d[w*DW +: DW] : '0;
    if (g) exp_q.push_back('{data: f, due: cyc + 1});
    @(posedge clk);
    cyc++;
    if (r) begin
      m_credits = NCRED; m_last = 3; m_mis = 0; m_ovf = 0;
    end else begin
      if (g) begin
        m_last = w;
        if (f[DW-1 -: 6] != LADDR) m_mis = 1;
      end
      if (g && !ci) m_credits--;
      else if (ci && !g) begin
        if (m_credits == NCRED) m_ovf = 1;
        else m_credits++;
      end
    end
    #1;
    check("credit_count", {28'b0, credit_count}, 32'(m_credits));
    check("current_grant", {30'b0, current_grant}, 32'(m_last));
    check("busy", {31'b0, busy}, {31'b0, m_credits < NCRED});
    check("misroute_err", {31'b0, misroute_err}, {31'b0, m_mis});
    check("credit_ovf_err", {31'b0, credit_ovf_err}, {31'b0, m_ovf});
  endtask

  function automatic logic [4*DW-1:0] all_local(input int base);
    logic [4*DW-1:0] d;
    for (int p = 0; p < 4; p++) d[p*DW +: DW] = flit(23, base + p);
    return d;
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a flit.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {16'b0, out_data}, {16'b0, e.data});
          check("out_latency", 32'(cyc), 32'(e.due));
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        check("missing_out_valid", {31'b0, out_valid}, 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [4*DW-1:0] d;
    int dest;

    // Reset with every port requesting.
    cycle(1, 1, 4'b1111, all_local(0), 0);
    cycle(1, 1, 4'b1111, all_local(0), 0);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_credit_count", {28'b0, credit_count}, 32'd4);
    check("reset_current_grant", {30'b0, current_grant}, 32'd3);

    // Single requester on port 2.
    d = '0; d[2*DW +: DW] = 16'h5C01;
    cycle(0, 1, 4'b0100, d, 0);
    cycle(0, 1, 4'b0000, d, 0);
    check("single_credit_count", {28'b0, credit_count}, 32'd3);

    // Round robin from reset until credits run out, then one credit return.
    cycle(1, 1, 4'b0000, '0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 4'b1111, all_local(16 * i), 0);
    check("exhausted_credit_count", {28'b0, credit_count}, 32'd0);
    cycle(0, 1, 4'b1111, all_local(100), 1);
    cycle(0, 1, 4'b1111, all_local(110), 0);
    check("after_return_grant", {30'b0, current_grant}, 32'd0);
    cycle(0, 1, 4'b1111, all_local(120), 0);

    // Grant and credit in the same cycle, then credit overflow.
    cycle(1, 1, 4'b0000, '0, 0);
    cycle(0, 1, 4'b0001, all_local(200), 0);
    cycle(0, 1, 4'b0001, all_local(210), 0);
    cycle(0, 1, 4'b0010, all_local(220), 1);
    check("simul_credit_count", {28'b0, credit_count}, 32'd2);
    cycle(0, 1, 4'b0000, '0, 1);
    cycle(0, 1, 4'b0000, '0, 1);
    cycle(0, 1, 4'b0000, '0, 1);
    cycle(0, 1, 4'b0000, '0, 0);
    check("ovf_sticky", {31'b0, credit_ovf_err}, 32'd1);

    // arb_enable low after a grant to port 1, then re-enable.
    cycle(1, 1, 4'b0000, '0, 0);
    cycle(0, 1, 4'b0010, all_local(300), 0);
    cycle(0, 0, 4'b0110, all_local(310), 0);
    cycle(0, 0, 4'b0110, all_local(320), 0);
    cycle(0, 1, 4'b0110, all_local(330), 0);
    check("reenable_grant", {30'b0, current_grant}, 32'd2);

    // Misrouted flit is forwarded and flagged until reset.
    d = '0; d[0 +: DW] = 16'h0401;
    cycle(0, 1, 4'b0001, d, 1);
    cycle(0, 1, 4'b0000, '0, 1);
    cycle(0, 1, 4'b0000, '0, 0);
    check("misroute_sticky", {31'b0, misroute_err}, 32'd1);
    cycle(1, 1, 4'b0000, '0, 0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 4; p++) begin
        dest = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 63)) : 23;
        d[p*DW +: DW] = flit(dest, int'($urandom_range(0, 1023)));
      end
      cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) != 0),
            4'($urandom_range(0, 15)), d,
            (m_credits < NCRED) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0));
    end

    cycle(0, 0, 4'b0000, '0, 0);
    cycle(0, 0, 4'b0000, '0, 0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
